// File: rtl/el2_pmp_csr_if.sv
// ============================================================================
// Module   : el2_pmp_csr_if
// Brief    : CSR access bus between the core CSR block and the PMP CSR file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface el2_pmp_csr_if;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  modport master (output csr_wr_en, csr_addr, csr_wdata, input csr_rdata, csr_hit);
  modport slave  (input csr_wr_en, csr_addr, csr_wdata, output csr_rdata, csr_hit);
endinterface

`default_nettype wire

// File: rtl/el2_pmp_csr.sv
// ============================================================================
// Module   : el2_pmp_csr
// Brief    : PMP configuration/address CSRs with Smepmp mseccfg lock rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module el2_pmp_csr #(
  parameter int PMP_ENTRIES = 16,
  parameter int SMEPMP      = 1
) (
  input  logic                          clk,
  input  logic                          rst_l,
  el2_pmp_csr_if.slave                  csr,
  output logic [PMP_ENTRIES-1:0][7:0]   pmp_pmpcfg,
  output logic [PMP_ENTRIES-1:0][31:0]  pmp_pmpaddr,
  output logic [2:0]                    mseccfg,
  output logic                          pmp_update
);

  localparam int c_CFG_WORDS = PMP_ENTRIES / 4;

  logic [7:0]  r_cfg  [PMP_ENTRIES];
  logic [31:0] r_addr [PMP_ENTRIES];
  logic        r_mml, r_mmwp, r_rlb, r_update;

  logic [7:0]  w_cfg_nxt  [PMP_ENTRIES];
  logic [31:0] w_addr_nxt [PMP_ENTRIES];
  logic        w_mml_nxt, w_mmwp_nxt, w_rlb_nxt;
  logic        w_cfg_sel, w_addr_sel, w_msec_sel, w_any_l, w_changed;
  logic [31:0] w_rdata;

  assign w_cfg_sel  = (csr.csr_addr[11:4] == 8'h3A) && ({1'b0, csr.csr_addr[3:0]} < 5'(c_CFG_WORDS));
  assign w_addr_sel = (csr.csr_addr[11:4] == 8'h3B) && ({1'b0, csr.csr_addr[3:0]} < 5'(PMP_ENTRIES));
  assign w_msec_sel = (csr.csr_addr == 12'h747);

  always_comb begin
    w_any_l = 1'b0;
    for (int i = 0; i < PMP_ENTRIES; i++) w_any_l = w_any_l | r_cfg[i][7];
  end

  for (genvar e = 0; e < PMP_ENTRIES; e++) begin : g_entry
    localparam int c_WORD = e / 4;
    localparam int c_BYTE = e % 4;
    logic [7:0] w_wbyte;
    logic       w_lock, w_tor_lock, w_illegal, w_cfg_we, w_addr_we;

    assign w_lock = r_cfg[e][7] & ~r_rlb;

    // A locked TOR entry also freezes the base address held in the entry below it
    if (e + 1 < PMP_ENTRIES) begin : g_tor
      assign w_tor_lock = r_cfg[e+1][7] & ~r_rlb & (r_cfg[e+1][4:3] == 2'b01);
    end else begin : g_last
      assign w_tor_lock = 1'b0;
    end

    always_comb begin
      w_wbyte = csr.csr_wdata[8*c_BYTE +: 8] & 8'h9F;
      if (!r_mml && (w_wbyte[1:0] == 2'b10)) w_wbyte[1:0] = 2'b00;
    end

    assign w_illegal = r_mml & ~r_rlb & w_wbyte[7]
                     & (w_wbyte[2] | (w_wbyte[1:0] == 2'b10))
                     & ~(w_wbyte[2:0] == 3'b111);

    assign w_cfg_we  = csr.csr_wr_en & w_cfg_sel & (csr.csr_addr[3:0] == 4'(c_WORD))
                     & ~w_lock & ~w_illegal;
    assign w_addr_we = csr.csr_wr_en & w_addr_sel & (csr.csr_addr[3:0] == 4'(e))
                     & ~w_lock & ~w_tor_lock;

    assign w_cfg_nxt[e]  = w_cfg_we  ? w_wbyte        : r_cfg[e];
    assign w_addr_nxt[e] = w_addr_we ? csr.csr_wdata  : r_addr[e];
  end

  if (SMEPMP != 0) begin : g_smepmp
    logic w_msec_we;
    assign w_msec_we  = csr.csr_wr_en & w_msec_sel;
    assign w_mml_nxt  = r_mml  | (w_msec_we & csr.csr_wdata[0]);
    assign w_mmwp_nxt = r_mmwp | (w_msec_we & csr.csr_wdata[1]);
    // RLB may only be raised while no entry is locked, or if already set
    assign w_rlb_nxt  = !w_msec_we          ? r_rlb :
                        !csr.csr_wdata[2]   ? 1'b0  :
                        (r_rlb | ~w_any_l);
  end else begin : g_no_smepmp
    assign w_mml_nxt  = 1'b0;
    assign w_mmwp_nxt = 1'b0;
    assign w_rlb_nxt  = 1'b0;
  end

  always_comb begin
    w_changed = (w_mml_nxt != r_mml) | (w_mmwp_nxt != r_mmwp) | (w_rlb_nxt != r_rlb);
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      w_changed = w_changed | (w_cfg_nxt[i] != r_cfg[i]) | (w_addr_nxt[i] != r_addr[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
      r_mml    <= 1'b0;
      r_mmwp   <= 1'b0;
      r_rlb    <= 1'b0;
      r_update <= 1'b0;
    end else begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        r_cfg[i]  <= w_cfg_nxt[i];
        r_addr[i] <= w_addr_nxt[i];
      end
      r_mml    <= w_mml_nxt;
      r_mmwp   <= w_mmwp_nxt;
      r_rlb    <= w_rlb_nxt;
      r_update <= w_changed;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (w_cfg_sel && (csr.csr_addr[3:0] == 4'(i / 4))) w_rdata[8*(i%4) +: 8] = r_cfg[i];
      if (w_addr_sel && (csr.csr_addr[3:0] == 4'(i)))    w_rdata = r_addr[i];
    end
    if (w_msec_sel) w_rdata = {29'b0, r_rlb, r_mmwp, r_mml};
  end

  always_comb begin
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      pmp_pmpcfg[i]  = r_cfg[i];
      pmp_pmpaddr[i] = r_addr[i];
    end
  end

  assign mseccfg       = {r_rlb, r_mmwp, r_mml};
  assign pmp_update    = r_update;
  assign csr.csr_rdata = w_rdata;
  assign csr.csr_hit   = w_cfg_sel | w_addr_sel | w_msec_sel;

endmodule

`default_nettype wire

// File: doc/el2_pmp_csr.md
EL2_PMP_CSR -- requirements
Module: css_mcu0_el2_pmp_csr

Interface
REQ-001 SHALL have parameter PMP_ENTRIES, default 16, giving the number of PMP entries (legal values 4, 8, 12, 16).
REQ-002 SHALL have parameter SMEPMP, default 1; 1 implements mseccfg, 0 makes mseccfg read zero and ignore writes.
REQ-003 SHALL have port clk, input, 1 bit: core clock, all state on rising edge.
REQ-004 SHALL have port rst_l, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port csr_wr_en, input, 1 bit: CSR write strobe, one write per cycle.
REQ-006 SHALL have port csr_addr, input, 12 bits: CSR address, used for both read and write.
REQ-007 SHALL have port csr_wdata, input, 32 bits: write data.
REQ-008 SHALL have port csr_rdata, output, 32 bits: combinational read data for csr_addr.
REQ-009 SHALL have port csr_hit, output, 1 bit: csr_addr decodes to an implemented CSR.
REQ-010 SHALL have port pmp_pmpcfg, output, PMP_ENTRIES x cfg packet: per-entry read, write, execute, mode[1:0], lock.
REQ-011 SHALL have port pmp_pmpaddr, output, PMP_ENTRIES x 32 bits: per-entry word address.
REQ-012 SHALL have port mseccfg, output, packet {RLB, MMWP, MML}.
REQ-013 SHALL have port pmp_update, output, 1 bit: one-cycle pulse, cycle after any accepted state change.

Function
REQ-014 SHALL map pmpcfgN at 0x3A0+N (N < PMP_ENTRIES/4), entry 4N+k in byte k: R=bit0, W=bit1, X=bit2, A=bits4:3, L=bit7; bits 6:5 read zero.
REQ-015 SHALL map pmpaddrI at 0x3B0+I (I < PMP_ENTRIES), all 32 bits writable; mseccfg at 0x747 (MML=bit0, MMWP=bit1, RLB=bit2, other bits zero).
REQ-016 SHALL read zero and assert csr_hit=0 for unimplemented addresses; writes to them are ignored.
REQ-017 SHALL update registers on the rising edge with csr_wr_en=1; outputs and csr_rdata reflect the new value from the next cycle (read-during-write returns old value).
REQ-018 SHALL treat a cfg byte as locked when stored L=1 and RLB=0; writes to a locked byte are ignored, other bytes of the same word still update.
REQ-019 SHALL ignore writes to pmpaddrI when entry I is locked, or when entry I+1 is locked with mode TOR (I+1 < PMP_ENTRIES).
REQ-020 SHALL, when MML=0, store a written byte with R=0,W=1 as R=0,W=0 (X, A, L as written).
REQ-021 SHALL, when MML=1 and RLB=0, ignore a cfg byte write whose new value has L=1 and (X=1 or (R=0,W=1)), except {L,R,W,X}=1111 which is accepted.
REQ-022 SHALL make MML and MMWP sticky: write of 1 sets, write of 0 has no effect, cleared only by reset.
REQ-023 SHALL accept RLB write of 0 always; RLB write of 1 only when RLB is already 1 or no entry has L=1.
REQ-024 SHALL evaluate lock and RLB conditions on pre-write state; a mseccfg write and cfg effects are never merged in one cycle.
REQ-025 SHALL assert pmp_update for exactly one cycle after a write that changed any stored bit; no pulse for fully ignored or no-change writes.

Reset
REQ-026 SHALL on rst_l=0 clear immediately all cfg bytes (mode OFF, L=0), all pmpaddr, MML, MMWP, RLB and pmp_update.
REQ-027 SHALL abandon a write coincident with reset assertion; no register updates while rst_l=0.

Verification
REQ-028 Write 0x3A0=0x0000_009F, then 0x3A0=0x0000_0000 -> pmp_pmpcfg[0]={L=1,A=NAPOT,X,W,R}=0x9F persists; pmp_update pulses once only.
REQ-029 Entry1 cfg=0x88 (L, TOR); write 0x3B0=0x1234 and 0x3B1=0x5678 -> both pmpaddr stay 0; entry2 pmpaddr write 0x9ABC accepted.
REQ-030 MML=0, write 0x3A0=0x0A0A_0A02 -> every byte reads back with W=0 (0x0808_0800); pmp_update pulses.
REQ-031 Write 0x747=0x3 then 0x747=0x0 -> mseccfg reads 0x3; then 0x3A0 byte0=0x84 ignored, byte0=0x87 accepted.
REQ-032 Entry0 L=1, write 0x747=0x4 -> RLB stays 0; after reset, write 0x747=0x4 then 0x3A0=0x80 then 0x3A0=0x00 -> byte0 reads 0x00.
REQ-033 Assert rst_l=0 mid-cycle with csr_wr_en=1 to 0x3B5 -> all outputs zero immediately, pmpaddr5 remains 0 after release.
